// File: rtl/sqrt_pkg.sv
// Shared constants, helpers and payload types for the square root operand path.
package sqrt_pkg;

    localparam int unsigned DEFAULT_DATA_WIDTH = 32;

    // Phase value after reset; the core's second post-reset IDLE cycle lines up with phase 0.
    localparam int unsigned PHASE_RESET = 1;

    function automatic int unsigned ITERATIONS_F(input int unsigned data_width);
        return data_width / 2;
    endfunction

    function automatic int unsigned PERIOD_F(input int unsigned data_width);
        return ITERATIONS_F(data_width) + 2;
    endfunction

    typedef struct packed {
        logic                          valid;
        logic [DEFAULT_DATA_WIDTH-1:0] radicand;
    } handshake_t;

endpackage

// File: rtl/sqrt_operand_queue_if.sv
// Producer-side handshake plus core-side issue signals of the operand queue.
interface sqrt_operand_queue_if #(
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned DEPTH      = 4
);
    localparam int unsigned CNT_W = $clog2(DEPTH) + 1;

    logic                  valid;
    logic [DATA_WIDTH-1:0] radicand;
    logic                  ready;
    logic [DATA_WIDTH-1:0] core_radicand;
    logic                  valid_entry;
    logic [CNT_W-1:0]      count;
    logic                  issue;

    modport master (
        output valid, radicand,
        input  ready, core_radicand, valid_entry, count, issue
    );

    modport slave (
        input  valid, radicand,
        output ready, core_radicand, valid_entry, count, issue
    );
endinterface

// File: rtl/sync_fifo.sv
// Single-clock FIFO with occupancy counter; storage is cleared on reset.
module sync_fifo #(
    parameter int unsigned DEPTH      = 4,
    parameter int unsigned DATA_WIDTH = 32,
    localparam int unsigned PTR_W     = $clog2(DEPTH),
    localparam int unsigned CNT_W     = $clog2(DEPTH) + 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  push,
    input  logic                  pop,
    input  logic [DATA_WIDTH-1:0] wdata,
    output logic [DATA_WIDTH-1:0] rdata,
    output logic                  full,
    output logic                  empty,
    output logic [CNT_W-1:0]      count
);
    logic [DATA_WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0]      wr_ptr;
    logic [PTR_W-1:0]      rd_ptr;
    logic                  do_push;
    logic                  do_pop;

    assign full    = (count == CNT_W'(DEPTH));
    assign empty   = (count == '0);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign rdata   = mem[rd_ptr];

    // Pointers wrap naturally since DEPTH is a power of two.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                mem[wr_ptr] <= wdata;
                wr_ptr      <= wr_ptr + PTR_W'(1);
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/sqrt_operand_queue.sv
// Operand FIFO feeding the square root core, issuing only in the core's IDLE sampling cycle.
module sqrt_operand_queue
    import sqrt_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned DEPTH      = 4,
    parameter int unsigned ITERATIONS = ITERATIONS_F(DATA_WIDTH),
    parameter int unsigned PERIOD     = ITERATIONS + 2
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 clk_en,
    sqrt_operand_queue_if.slave  bus
);
    localparam int unsigned PHASE_W = $clog2(PERIOD);
    localparam int unsigned CNT_W   = $clog2(DEPTH) + 1;

    logic [PHASE_W-1:0]    phase_q;
    logic [PHASE_W-1:0]    phase_d;
    logic                  phase_zero;
    logic                  push;
    logic                  pop;
    logic                  full;
    logic                  empty;
    logic [CNT_W-1:0]      count;
    logic [DATA_WIDTH-1:0] head;

    assign phase_zero = (phase_q == '0);
    assign push       = clk_en && bus.valid && !full;
    assign pop        = clk_en && phase_zero && !empty;

    // Core samples head and valid_entry in the same cycle they are presented.
    assign bus.ready         = !full;
    assign bus.core_radicand = head;
    assign bus.valid_entry   = pop;
    assign bus.issue         = pop;
    assign bus.count         = count;

    // Phase mirrors the core's period and reloads whether or not data was issued.
    always_comb begin
        phase_d = phase_q;
        if (clk_en) begin
            phase_d = phase_zero ? PHASE_W'(PERIOD - 1) : phase_q - PHASE_W'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            phase_q <= PHASE_W'(PHASE_RESET);
        end else begin
            phase_q <= phase_d;
        end
    end

    sync_fifo #(
        .DEPTH      (DEPTH),
        .DATA_WIDTH (DATA_WIDTH)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (push),
        .pop   (pop),
        .wdata (bus.radicand),
        .rdata (head),
        .full  (full),
        .empty (empty),
        .count (count)
    );

endmodule

// File: tb/tb_sqrt_operand_queue.sv
// Scenario bench for sqrt_operand_queue with a per-cycle scoreboard of issue order and timing.
module tb_sqrt_operand_queue;
    import sqrt_pkg::*;

    localparam int unsigned DW     = 32;
    localparam int unsigned DEPTH  = 4;
    localparam int unsigned PERIOD = PERIOD_F(DW);

    logic clk    = 1'b0;
    logic rst    = 1'b1;
    logic clk_en = 1'b1;

    int n_cmp = 0;
    int n_bad = 0;
    int cyc   = 0;

    logic [DW-1:0] sb [$];
    int unsigned   mphase = 1;

    sqrt_operand_queue_if #(.DATA_WIDTH(DW), .DEPTH(DEPTH)) bus ();

    sqrt_operand_queue #(.DATA_WIDTH(DW), .DEPTH(DEPTH)) dut (
        .clk    (clk),
        .rst    (rst),
        .clk_en (clk_en),
        .bus    (bus)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Scoreboard: reference occupancy, phase and issue order, checked mid-cycle.
    always @(negedge clk) begin
        logic       exp_issue;
        logic       full_pre;
        logic [DW-1:0] exp_r;
        handshake_t got;
        if (rst) begin
            sb.delete();
            mphase = 1;
        end else begin
            full_pre  = (sb.size() >= DEPTH);
            exp_issue = clk_en && (mphase == 0) && (sb.size() != 0);
            n_cmp++;
            if (bus.issue !== exp_issue) begin
                n_bad++;
                $display("FAIL sb_issue: cycle %0d got %b expected %b", cyc, bus.issue, exp_issue);
            end
            n_cmp++;
            if (bus.valid_entry !== exp_issue) begin
                n_bad++;
                $display("FAIL sb_valid_entry: cycle %0d got %b expected %b", cyc, bus.valid_entry, exp_issue);
            end
            n_cmp++;
            if (bus.ready !== !full_pre) begin
                n_bad++;
                $display("FAIL sb_ready: cycle %0d got %b expected %b", cyc, bus.ready, !full_pre);
            end
            n_cmp++;
            if (bus.count !== 3'(sb.size())) begin
                n_bad++;
                $display("FAIL sb_count: cycle %0d got %0d expected %0d", cyc, bus.count, sb.size());
            end
            if (exp_issue) begin
                exp_r = sb.pop_front();
                got   = '{valid: bus.valid_entry, radicand: bus.core_radicand};
                n_cmp++;
                if (got.radicand !== exp_r) begin
                    n_bad++;
                    $display("FAIL sb_radicand: cycle %0d got %h expected %h", cyc, got.radicand, exp_r);
                end
            end
            if (clk_en && bus.valid && !full_pre) sb.push_back(bus.radicand);
            if (clk_en) mphase = (mphase == 0) ? PERIOD - 1 : mphase - 1;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_phase(input int unsigned p, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 2 * PERIOD; i++) begin
            if (mphase == p) begin
                ok = 1'b1;
                return;
            end
            tick();
        end
    endtask

    task automatic wait_issue(input int bound, output int t, output bit ok);
        ok = 1'b0;
        t  = -1;
        for (int i = 0; i < bound; i++) begin
            if (bus.issue === 1'b1) begin
                ok = 1'b1;
                t  = cyc;
                return;
            end
            tick();
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        bus.valid = 1'b0;
        bus.radicand = '0;
        repeat (3) tick();
        n_cmp++; if (bus.count !== 3'd0) begin n_bad++; $display("FAIL reset_count: got %0d expected 0", bus.count); end
        n_cmp++; if (bus.ready !== 1'b1) begin n_bad++; $display("FAIL reset_ready: got %b expected 1", bus.ready); end
        n_cmp++; if (bus.valid_entry !== 1'b0) begin n_bad++; $display("FAIL reset_valid_entry: got %b expected 0", bus.valid_entry); end
        n_cmp++; if (bus.issue !== 1'b0) begin n_bad++; $display("FAIL reset_issue: got %b expected 0", bus.issue); end
        n_cmp++; if (bus.core_radicand !== 32'h0) begin n_bad++; $display("FAIL reset_radicand: got %h expected 0", bus.core_radicand); end
        rst = 1'b0;
    endtask

    task automatic test_single();
        bus.valid = 1'b1;
        bus.radicand = 32'h0000_0010;
        tick();
        bus.valid = 1'b0;
        n_cmp++; if (bus.issue !== 1'b1) begin n_bad++; $display("FAIL single_issue: got %b expected 1", bus.issue); end
        n_cmp++; if (bus.core_radicand !== 32'h0000_0010) begin n_bad++; $display("FAIL single_radicand: got %h expected 00000010", bus.core_radicand); end
        tick();
    endtask

    task automatic test_back_to_back();
        logic [DW-1:0] v [3];
        int t [3];
        bit ok;
        v[0] = 32'hFFFF_FFFF; v[1] = 32'h0000_0002; v[2] = 32'h0000_0019;
        for (int i = 0; i < 3; i++) begin
            bus.valid = 1'b1;
            bus.radicand = v[i];
            tick();
        end
        bus.valid = 1'b0;
        for (int i = 0; i < 3; i++) begin
            wait_issue(2 * PERIOD, t[i], ok);
            n_cmp++;
            if (!ok) begin n_bad++; $display("FAIL b2b_timeout: issue %0d never seen", i); end
            tick();
        end
        for (int i = 1; i < 3; i++) begin
            n_cmp++;
            if (t[i] - t[i-1] !== PERIOD) begin
                n_bad++;
                $display("FAIL b2b_spacing: gap %0d got %0d expected %0d", i, t[i] - t[i-1], PERIOD);
            end
        end
    endtask

    task automatic test_fill();
        bit ok;
        int t_iss;
        int guard;
        t_iss = -1;
        wait_phase(10, ok);
        n_cmp++; if (!ok) begin n_bad++; $display("FAIL fill_sync: phase 10 not reached"); end
        for (int i = 0; i < 5; i++) begin
            bus.valid = 1'b1;
            bus.radicand = 32'hA000_0000 + 32'(i);
            guard = 0;
            while (bus.ready !== 1'b1 && guard < 3 * PERIOD) begin
                if (bus.issue === 1'b1) begin
                    t_iss = cyc;
                    n_cmp++;
                    if (bus.ready !== 1'b0) begin n_bad++; $display("FAIL fill_no_bypass: got ready %b expected 0", bus.ready); end
                end
                tick();
                guard++;
            end
            if (i == 4) begin
                n_cmp++;
                if (cyc - t_iss !== 1) begin n_bad++; $display("FAIL fill_ready_rise: got %0d cycles after issue expected 1", cyc - t_iss); end
            end
            tick();
            if (i == 3) begin
                n_cmp++; if (bus.ready !== 1'b0) begin n_bad++; $display("FAIL fill_full_ready: got %b expected 0", bus.ready); end
                n_cmp++; if (bus.count !== 3'd4) begin n_bad++; $display("FAIL fill_full_count: got %0d expected 4", bus.count); end
            end
        end
        bus.valid = 1'b0;
        guard = 0;
        while (bus.count !== 3'd0 && guard < 6 * PERIOD) begin
            tick();
            guard++;
        end
        n_cmp++; if (bus.count !== 3'd0) begin n_bad++; $display("FAIL fill_drain: got count %0d expected 0", bus.count); end
    endtask

    task automatic test_empty_phase0();
        bit ok;
        wait_phase(0, ok);
        n_cmp++; if (!ok) begin n_bad++; $display("FAIL empty_sync: phase 0 not reached"); end
        n_cmp++; if (bus.valid_entry !== 1'b0) begin n_bad++; $display("FAIL empty_valid_entry: got %b expected 0", bus.valid_entry); end
        n_cmp++; if (bus.issue !== 1'b0) begin n_bad++; $display("FAIL empty_issue: got %b expected 0", bus.issue); end
        tick();
        wait_phase(5, ok);
        bus.valid = 1'b1;
        bus.radicand = 32'h0000_0051;
        tick();
        bus.valid = 1'b0;
        for (int k = 1; k <= 5; k++) begin
            n_cmp++;
            if (bus.issue !== (k == 5)) begin
                n_bad++;
                $display("FAIL empty_late_push: cycle +%0d got issue %b expected %b", k, bus.issue, (k == 5));
            end
            tick();
        end
    endtask

    task automatic test_clk_en();
        bit ok;
        int t_push;
        int t_iss;
        wait_phase(6, ok);
        n_cmp++; if (!ok) begin n_bad++; $display("FAIL clken_sync: phase 6 not reached"); end
        t_push = cyc;
        bus.valid = 1'b1;
        bus.radicand = 32'h0000_0024;
        tick();
        bus.valid = 1'b0;
        tick();
        tick();
        clk_en = 1'b0;
        bus.valid = 1'b1;
        bus.radicand = 32'hDEAD_BEEF;
        for (int k = 0; k < 7; k++) begin
            n_cmp++;
            if (bus.count !== 3'd1 || bus.issue !== 1'b0 || bus.valid_entry !== 1'b0) begin
                n_bad++;
                $display("FAIL clken_freeze: k=%0d count %0d issue %b valid_entry %b expected 1/0/0", k, bus.count, bus.issue, bus.valid_entry);
            end
            tick();
        end
        clk_en = 1'b1;
        bus.valid = 1'b0;
        wait_issue(2 * PERIOD, t_iss, ok);
        n_cmp++;
        if (!ok || t_iss - t_push !== 13) begin
            n_bad++;
            $display("FAIL clken_latency: got %0d cycles expected 13", t_iss - t_push);
        end
        n_cmp++; if (bus.core_radicand !== 32'h0000_0024) begin n_bad++; $display("FAIL clken_radicand: got %h expected 00000024", bus.core_radicand); end
        tick();
    endtask

    task automatic test_reset_mid();
        bit ok;
        wait_phase(12, ok);
        for (int i = 0; i < 3; i++) begin
            bus.valid = 1'b1;
            bus.radicand = 32'hC000_0000 + 32'(i);
            tick();
        end
        bus.valid = 1'b0;
        n_cmp++; if (bus.count !== 3'd3) begin n_bad++; $display("FAIL rmid_pre_count: got %0d expected 3", bus.count); end
        #2 rst = 1'b1;
        #1;
        n_cmp++; if (bus.count !== 3'd0) begin n_bad++; $display("FAIL rmid_count: got %0d expected 0", bus.count); end
        n_cmp++; if (bus.ready !== 1'b1) begin n_bad++; $display("FAIL rmid_ready: got %b expected 1", bus.ready); end
        n_cmp++; if (bus.core_radicand !== 32'h0) begin n_bad++; $display("FAIL rmid_radicand: got %h expected 0", bus.core_radicand); end
        tick();
        rst = 1'b0;
        bus.valid = 1'b1;
        bus.radicand = 32'h0000_0099;
        tick();
        bus.valid = 1'b0;
        n_cmp++; if (bus.issue !== 1'b1) begin n_bad++; $display("FAIL rmid_issue: got %b expected 1", bus.issue); end
        n_cmp++; if (bus.core_radicand !== 32'h0000_0099) begin n_bad++; $display("FAIL rmid_issue_radicand: got %h expected 00000099", bus.core_radicand); end
        repeat (3) tick();
    endtask

    initial begin
        bus.valid = 1'b0;
        bus.radicand = '0;
        test_reset();
        test_single();
        test_back_to_back();
        test_fill();
        test_empty_phase0();
        test_clk_en();
        test_reset_mid();
        n_cmp++;
        if (sb.size() != 0) begin n_bad++; $display("FAIL final_scoreboard: %0d operands never issued", sb.size()); end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

endmodule
